// File: rtl/swap_checker.sv
// ----------------------------------------------------------------------------
// swap_checker
//
// Receive-side health monitor for a two-register swap stream. The observed
// pair (a_i, b_i) is expected to exchange its two bits on every enabled
// update. The checker trains on consecutive good swaps, locks after LOCK_CNT
// of them, and once locked flags and counts every swap violation.
//
// Parameters:
//   LOCK_CNT   consecutive matching samples needed to lock (1..15)
//   ERR_CNT_W  width of the saturating violation counter
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset (priority over everything)
//   en_i       sample qualifier; a_i/b_i ignored while low
//   a_i, b_i   observed pair
//   clr_i      synchronous clear of err_cnt_o only
//   locked_o   high while locked
//   err_o      one-cycle pulse per violation seen while locked
//   err_cnt_o  saturating count of violations
// ----------------------------------------------------------------------------
module swap_checker #(
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 a_i,
    input  logic                 b_i,
    input  logic                 clr_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTrain  = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 prev_a_q, prev_a_d;
    logic                 prev_b_q, prev_b_d;
    logic [3:0]           good_cnt_q, good_cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       match;
    logic [3:0] good_cnt_inc;
    logic [3:0] lock_target;
    logic       err_cnt_sat;

    // A sample is good when it is the previous sample with its bits exchanged.
    // Equal-valued pairs therefore match themselves.
    assign match        = (a_i == prev_b_q) && (b_i == prev_a_q);
    assign good_cnt_inc = good_cnt_q + 4'd1;
    assign lock_target  = 4'(LOCK_CNT);
    assign err_cnt_sat  = &err_cnt_q;

    // ------------------------------------------------------------------------
    // Next-state: FSM, sample history and training counter
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        prev_a_d   = prev_a_q;
        prev_b_d   = prev_b_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;

        if (en_i) begin
            // History tracks every enabled sample, good or bad, in any state.
            prev_a_d = a_i;
            prev_b_d = b_i;

            unique case (state_q)
                StIdle: begin
                    // First sample after reset only seeds the history.
                    good_cnt_d = 4'd0;
                    state_d    = StTrain;
                end
                StTrain: begin
                    if (match) begin
                        if (good_cnt_inc == lock_target) begin
                            state_d    = StLocked;
                            good_cnt_d = 4'd0;
                        end else begin
                            good_cnt_d = good_cnt_inc;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (!match) begin
                        err_d      = 1'b1;
                        state_d    = StTrain;
                        good_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    good_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // locked_o comes straight from a flop rather than a state decode.
    assign locked_d = (state_d == StLocked);

    // ------------------------------------------------------------------------
    // Next-state: saturating violation counter
    // ------------------------------------------------------------------------
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            // A violation in the clearing cycle is counted after the clear.
            err_cnt_d = err_d ? ERR_CNT_W'(1) : '0;
        end else if (err_d && !err_cnt_sat) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prev_a_q   <= 1'b0;
            prev_b_q   <= 1'b0;
            good_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_swap_checker.sv
// ----------------------------------------------------------------------------
// tb_swap_checker
//
// Drives two swap_checker instances from the same stimulus: one with
// LOCK_CNT=4/ERR_CNT_W=8 and one with LOCK_CNT=1/ERR_CNT_W=2. Each is compared
// every cycle against a behavioural model, with extra directed checks at the
// points of interest, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_swap_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b0;
    logic       a_i = 1'b0;
    logic       b_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       locked0, err0, locked1, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, one slot per DUT instance.
    int lock_req [2] = '{4, 1};
    int cnt_max  [2] = '{255, 3};
    bit m_started[2];
    bit m_pa     [2];
    bit m_pb     [2];
    int m_run    [2];
    bit m_locked [2];
    bit m_err    [2];
    int m_cnt    [2];

    int pulses1;

    always #5 clk = ~clk;

    swap_checker #(.LOCK_CNT(4), .ERR_CNT_W(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .clr_i    (clr_i),
        .locked_o (locked0),
        .err_o    (err0),
        .err_cnt_o(cnt0)
    );

    swap_checker #(.LOCK_CNT(1), .ERR_CNT_W(2)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .clr_i    (clr_i),
        .locked_o (locked1),
        .err_o    (err1),
        .err_cnt_o(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Model: a run of consecutive matching samples after the seeding sample;
    // reaching the required run length locks, a bad sample while locked is a
    // violation that drops back to training.
    task automatic model_update(input int i, input bit r, input bit e, input bit a,
                                input bit b, input bit c);
        bit viol;
        bit good;
        viol = 1'b0;
        if (!r) begin
            m_started[i] = 1'b0;
            m_pa[i] = 1'b0;
            m_pb[i] = 1'b0;
            m_run[i] = 0;
            m_locked[i] = 1'b0;
            m_err[i] = 1'b0;
            m_cnt[i] = 0;
            return;
        end
        if (e) begin
            good = (a == m_pb[i]) && (b == m_pa[i]);
            if (!m_started[i]) begin
                m_started[i] = 1'b1;
                m_run[i] = 0;
            end else if (m_locked[i]) begin
                if (!good) begin
                    viol = 1'b1;
                    m_locked[i] = 1'b0;
                    m_run[i] = 0;
                end
            end else if (good) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= lock_req[i]) begin
                    m_locked[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_pa[i] = a;
            m_pb[i] = b;
        end
        m_err[i] = viol;
        if (c) m_cnt[i] = viol ? 1 : 0;
        else if (viol && m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic step(input bit r, input bit e, input bit a, input bit b, input bit c);
        rst_n = r;
        en_i  = e;
        a_i   = a;
        b_i   = b;
        clr_i = c;
        @(posedge clk);
        model_update(0, r, e, a, b, c);
        model_update(1, r, e, a, b, c);
        #1;
        chk("locked0", 32'(locked0), 32'(m_locked[0]));
        chk("err0",    32'(err0),    32'(m_err[0]));
        chk("cnt0",    32'(cnt0),    32'(m_cnt[0]));
        chk("locked1", 32'(locked1), 32'(m_locked[1]));
        chk("err1",    32'(err1),    32'(m_err[1]));
        chk("cnt1",    32'(cnt1),    32'(m_cnt[1]));
        if (err1 === 1'b1) pulses1++;
    endtask

    initial begin
        bit r, e, a, b, c;

        // Reset held with enabled random traffic.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            chk("rst_locked", 32'(locked0), 32'd0);
            chk("rst_err",    32'(err0),    32'd0);
            chk("rst_cnt",    32'(cnt0),    32'd0);
        end

        // Lock after 1 + 4 enabled samples.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lock_edge4", 32'(locked0), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lock_edge5", 32'(locked0), 32'd1);
        chk("lock_noerr", 32'(err0), 32'd0);

        // Violation, then relock on self-matching (1,1).
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("viol_err",    32'(err0),    32'd1);
        chk("viol_cnt",    32'(cnt0),    32'd1);
        chk("viol_locked", 32'(locked0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("relock_noerr", 32'(err0), 32'd0);
        end
        chk("relock", 32'(locked0), 32'd1);

        // Enable gaps with garbage do not disturb training.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap_not_yet", 32'(locked0), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_lock", 32'(locked0), 32'd1);

        // Saturation and clear on the LOCK_CNT=1 / 2-bit instance.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulses1 = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, m_pb[1], m_pa[1], 1'b0);
            chk("sat_locked", 32'(locked1), 32'd1);
            step(1'b1, 1'b1, ~m_pb[1], m_pa[1], 1'b0);
        end
        chk("sat_pulses", 32'(pulses1), 32'd5);
        chk("sat_cnt",    32'(cnt1),    32'd3);
        step(1'b1, 1'b1, m_pb[1], m_pa[1], 1'b0);
        step(1'b1, 1'b1, ~m_pb[1], m_pa[1], 1'b1);
        chk("clr_err_pulse", 32'(err1), 32'd1);
        chk("clr_with_err",  32'(cnt1), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_alone", 32'(cnt1), 32'd0);

        // Mid-operation reset while locked.
        step(1'b1, 1'b1, m_pb[0], m_pa[0], 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, m_pb[0], m_pa[0], 1'b0);
        chk("pre_rst_locked", 32'(locked0), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_locked", 32'(locked0), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_rst_noerr",  32'(err0),    32'd0);
        chk("post_rst_locked", 32'(locked0), 32'd0);

        // Randomized traffic, mostly well-formed swaps.
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) != 0) begin
                a = m_pb[0];
                b = m_pa[0];
            end else begin
                a = 1'($urandom);
                b = 1'($urandom);
            end
            step(r, e, a, b, c);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
